// File: rtl/ga_sync_pkg.sv
// Shared defaults, counter widths and FSM state types for the gate-array sync consumer.
package ga_sync_pkg;

  localparam int GA_HDELAY     = 2;
  localparam int GA_HWIDTH     = 4;
  localparam int GA_VDELAY     = 2;
  localparam int GA_VWIDTH     = 4;
  localparam int GA_INT_LINES  = 52;
  localparam int GA_INT_MIN_VS = 32;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_DELAY  = 2'd1,
    H_ACTIVE = 2'd2,
    H_HOLD   = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    V_IDLE   = 2'd0,
    V_WAIT   = 2'd1,
    V_ACTIVE = 2'd2
  } v_state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'd15) ? 4'd15 : value + 4'd1;
  endfunction

endpackage

// File: rtl/ga_sync_edge.sv
// Character-clock sampler for one CRTC sync line; rise/fall are only
// flagged on enabled cycles and compare against the previous enabled sample.
module ga_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic sync_i,
  output logic rise_o,
  output logic fall_o
);

  logic sample_q;

  // Previous enabled sample of the sync line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= 1'b0;
    end else if (en_i) begin
      sample_q <= sync_i;
    end else begin
      sample_q <= sample_q;
    end
  end

  assign rise_o = en_i & sync_i & ~sample_q;
  assign fall_o = en_i & ~sync_i & sample_q;

endmodule

// File: rtl/ga_sync_int.sv
// Gate-array sync consumer: delayed, width-limited monitor syncs, per-line
// mode latch and the R52 raster interrupt counter feeding the Z80 INT line.
module ga_sync_int
  import ga_sync_pkg::*;
#(
  parameter int HDELAY     = GA_HDELAY,
  parameter int HWIDTH     = GA_HWIDTH,
  parameter int VDELAY     = GA_VDELAY,
  parameter int VWIDTH     = GA_VWIDTH,
  parameter int INT_LINES  = GA_INT_LINES,
  parameter int INT_MIN_VS = GA_INT_MIN_VS
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic       CRTC_HSYNC,
  input  logic       CRTC_VSYNC,
  input  logic [1:0] MODE_REQ,
  input  logic       INT_ACK,
  input  logic       INT_RST,
  output logic       MON_HSYNC,
  output logic       MON_VSYNC,
  output logic [1:0] MODE,
  output logic       INT,
  output logic [5:0] R52
);

  localparam logic [3:0] H_ON     = 4'(HDELAY);
  localparam logic [3:0] H_OFF    = 4'(HDELAY + HWIDTH);
  localparam logic [3:0] V_ON     = 4'(VDELAY);
  localparam logic [3:0] V_OFF    = 4'(VDELAY + VWIDTH);
  localparam logic [5:0] R52_LAST = 6'(INT_LINES - 1);
  localparam logic [5:0] R52_MIN  = 6'(INT_MIN_VS);

  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [3:0] vcnt_q, vcnt_d;
  logic       mon_hs_q, mon_hs_d;
  logic       mon_vs_q, mon_vs_d;
  logic [1:0] mode_q, mode_d;
  logic       int_q, int_d;
  logic [5:0] r52_q, r52_d;

  logic       hs_rise_s, hs_end_s, vs_rise_s, vs_fall_unused_s;
  logic [3:0] vcnt_inc_s;
  logic       v_reach_s, int_set_s;
  logic [5:0] r52_step_s;

  ga_sync_edge u_hs_edge (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .en_i   (CLKEN),
    .sync_i (CRTC_HSYNC),
    .rise_o (hs_rise_s),
    .fall_o (hs_end_s)
  );

  ga_sync_edge u_vs_edge (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .en_i   (CLKEN),
    .sync_i (CRTC_VSYNC),
    .rise_o (vs_rise_s),
    .fall_o (vs_fall_unused_s)
  );

  assign vcnt_inc_s = vcnt_q + 4'd1;

  // H FSM: hcnt_q holds the chars elapsed since the rise, so it is compared before incrementing.
  always_comb begin
    h_state_d = h_state_q;
    hcnt_d    = hcnt_q;
    mon_hs_d  = mon_hs_q;
    mode_d    = mode_q;
    if (!CLKEN) begin
      h_state_d = h_state_q;
    end else if (!CRTC_HSYNC) begin
      h_state_d = H_IDLE;
      hcnt_d    = 4'd0;
      mon_hs_d  = 1'b0;
    end else if (hs_rise_s) begin
      h_state_d = H_DELAY;
      hcnt_d    = 4'd1;
      mode_d    = MODE_REQ;
    end else begin
      hcnt_d = sat_inc4(hcnt_q);
      case (h_state_q)
        H_DELAY: begin
          if (hcnt_q == H_ON) begin
            h_state_d = H_ACTIVE;
            mon_hs_d  = 1'b1;
          end else begin
            h_state_d = H_DELAY;
          end
        end
        H_ACTIVE: begin
          if (hcnt_q == H_OFF) begin
            h_state_d = H_HOLD;
            mon_hs_d  = 1'b0;
          end else begin
            h_state_d = H_ACTIVE;
          end
        end
        default: h_state_d = h_state_q;
      endcase
    end
  end

  // V FSM: a VSYNC rise always restarts the line count, even mid-pulse.
  always_comb begin
    v_state_d = v_state_q;
    vcnt_d    = vcnt_q;
    mon_vs_d  = mon_vs_q;
    v_reach_s = 1'b0;
    if (vs_rise_s) begin
      v_state_d = V_WAIT;
      vcnt_d    = 4'd0;
      mon_vs_d  = 1'b0;
    end else if (hs_end_s && (v_state_q != V_IDLE)) begin
      vcnt_d = vcnt_inc_s;
      if (vcnt_inc_s == V_ON) begin
        v_state_d = V_ACTIVE;
        mon_vs_d  = 1'b1;
        v_reach_s = 1'b1;
      end else if (vcnt_inc_s == V_OFF) begin
        v_state_d = V_IDLE;
        mon_vs_d  = 1'b0;
      end else begin
        v_state_d = v_state_q;
      end
    end else begin
      v_state_d = v_state_q;
    end
  end

  // R52/INT: line step first, then ACK and RMR reset layered on top in priority order.
  always_comb begin
    int_set_s  = 1'b0;
    r52_step_s = r52_q;
    if (!hs_end_s) begin
      r52_step_s = r52_q;
    end else if (v_reach_s) begin
      int_set_s  = (r52_q >= R52_MIN);
      r52_step_s = 6'd0;
    end else if (r52_q == R52_LAST) begin
      int_set_s  = 1'b1;
      r52_step_s = 6'd0;
    end else begin
      r52_step_s = r52_q + 6'd1;
    end
    r52_d = INT_RST ? 6'd0 : (INT_ACK ? (r52_step_s & 6'b01_1111) : r52_step_s);
    int_d = INT_RST ? 1'b0 : (int_set_s ? 1'b1 : (INT_ACK ? 1'b0 : int_q));
  end

  // State and output registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      h_state_q <= H_IDLE;
      v_state_q <= V_IDLE;
      hcnt_q    <= 4'd0;
      vcnt_q    <= 4'd0;
      mon_hs_q  <= 1'b0;
      mon_vs_q  <= 1'b0;
      mode_q    <= 2'd0;
      int_q     <= 1'b0;
      r52_q     <= 6'd0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      mon_hs_q  <= mon_hs_d;
      mon_vs_q  <= mon_vs_d;
      mode_q    <= mode_d;
      int_q     <= int_d;
      r52_q     <= r52_d;
    end
  end

  assign MON_HSYNC = mon_hs_q;
  assign MON_VSYNC = mon_vs_q;
  assign MODE      = mode_q;
  assign INT       = int_q;
  assign R52       = r52_q;

endmodule

// File: tb/tb_ga_sync_int.sv
// Self-checking bench for ga_sync_int: directed scenarios with literal
// expectations, then randomized sync/ack traffic against a behavioural model.
module tb_ga_sync_int;

  localparam int HD    = 2;
  localparam int HW    = 4;
  localparam int VD    = 2;
  localparam int VW    = 4;
  localparam int NL    = 52;
  localparam int MINVS = 32;

  logic       CLOCK      = 1'b0;
  logic       RESET      = 1'b1;
  logic       CLKEN      = 1'b0;
  logic       CRTC_HSYNC = 1'b0;
  logic       CRTC_VSYNC = 1'b0;
  logic [1:0] MODE_REQ   = 2'd0;
  logic       INT_ACK    = 1'b0;
  logic       INT_RST    = 1'b0;
  logic       MON_HSYNC, MON_VSYNC, INT;
  logic [1:0] MODE;
  logic [5:0] R52;

  int n_pass  = 0;
  int n_total = 0;

  // Model: chars the HSYNC has been high, HSYNC-ends since the last VSYNC rise (-1 = none).
  bit         m_prev_hs, m_prev_vs, m_int;
  int         m_run, m_vcount, m_r52;
  logic [1:0] m_mode;

  ga_sync_int dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .CLKEN      (CLKEN),
    .CRTC_HSYNC (CRTC_HSYNC),
    .CRTC_VSYNC (CRTC_VSYNC),
    .MODE_REQ   (MODE_REQ),
    .INT_ACK    (INT_ACK),
    .INT_RST    (INT_RST),
    .MON_HSYNC  (MON_HSYNC),
    .MON_VSYNC  (MON_VSYNC),
    .MODE       (MODE),
    .INT        (INT),
    .R52        (R52)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_prev_hs = 1'b0; m_prev_vs = 1'b0; m_int = 1'b0;
    m_run = 0; m_vcount = -1; m_r52 = 0; m_mode = 2'd0;
  endtask

  task automatic model_step();
    bit hr, he, vr, reach, set_int;
    hr = 1'b0; he = 1'b0; vr = 1'b0; reach = 1'b0; set_int = 1'b0;
    if (CLKEN) begin
      hr = CRTC_HSYNC && !m_prev_hs;
      he = !CRTC_HSYNC && m_prev_hs;
      vr = CRTC_VSYNC && !m_prev_vs;
      if (!CRTC_HSYNC) m_run = 0;
      else if (hr) begin m_run = 1; m_mode = MODE_REQ; end
      else if (m_run < 100) m_run++;
      if (vr) m_vcount = 0;
      else if (he && m_vcount >= 0 && m_vcount < VD + VW) begin
        m_vcount++;
        reach = (m_vcount == VD);
      end
      if (he) begin
        if (reach) begin
          set_int = (m_r52 >= MINVS);
          m_r52 = 0;
        end else begin
          m_r52 = (m_r52 + 1) % NL;
          set_int = (m_r52 == 0);
        end
      end
      if (set_int) m_int = 1'b1;
      m_prev_hs = CRTC_HSYNC;
      m_prev_vs = CRTC_VSYNC;
    end
    if (INT_ACK) begin
      m_r52 = m_r52 % 32;
      if (!set_int) m_int = 1'b0;
    end
    if (INT_RST) begin m_r52 = 0; m_int = 1'b0; end
  endtask

  task automatic compare_all();
    chk("mon_hsync", 8'(MON_HSYNC), 8'((m_run - 1 >= HD) && (m_run - 1 < HD + HW)));
    chk("mon_vsync", 8'(MON_VSYNC), 8'((m_vcount >= VD) && (m_vcount < VD + VW)));
    chk("mode", 8'(MODE), 8'(m_mode));
    chk("int", 8'(INT), 8'(m_int));
    chk("r52", 8'(R52), 8'(m_r52));
  endtask

  // One clock: inputs are already set at the negedge; outputs checked 1 time unit after posedge.
  task automatic cycle();
    model_step();
    @(posedge CLOCK);
    #1;
    compare_all();
    @(negedge CLOCK);
  endtask

  task automatic char_cycle(input bit hs, input bit vs, input bit ack, input bit rst);
    CLKEN = 1'b1; CRTC_HSYNC = hs; CRTC_VSYNC = vs; INT_ACK = ack; INT_RST = rst;
    cycle();
    CLKEN = 1'b0; INT_ACK = 1'b0; INT_RST = 1'b0;
    cycle();
  endtask

  task automatic hpulse(input int w, input int gap, input bit vs);
    for (int i = 0; i < w; i++) char_cycle(1'b1, vs, 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) char_cycle(1'b0, vs, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    CLKEN = 1'b0; CRTC_HSYNC = 1'b0; CRTC_VSYNC = 1'b0;
    INT_ACK = 1'b0; INT_RST = 1'b0; MODE_REQ = 2'd0;
    RESET = 1'b1;
    model_reset();
    repeat (2) @(negedge CLOCK);
    chk("rst_mon_hsync", 8'(MON_HSYNC), 8'd0);
    chk("rst_mon_vsync", 8'(MON_VSYNC), 8'd0);
    chk("rst_mode", 8'(MODE), 8'd0);
    chk("rst_int", 8'(INT), 8'd0);
    chk("rst_r52", 8'(R52), 8'd0);
    RESET = 1'b0;
    cycle();
  endtask

  initial begin
    bit hs_v, vs_v;
    int hs_left, vs_left;

    reset_dut();

    // Wide HSYNC: monitor pulse clipped to HWIDTH after HDELAY.
    repeat (2) char_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      char_cycle(1'(k < 14), 1'b0, 1'b0, 1'b0);
      chk("t1_mon_hsync", 8'(MON_HSYNC), 8'(k >= 2 && k <= 5));
    end

    // Short HSYNCs: 3 chars gives a 1-char pulse, 2 chars gives none.
    for (int k = 0; k < 8; k++) begin
      char_cycle(1'(k < 3), 1'b0, 1'b0, 1'b0);
      chk("t2_mon_hsync_3w", 8'(MON_HSYNC), 8'(k == 2));
    end
    for (int k = 0; k < 8; k++) begin
      char_cycle(1'(k < 2), 1'b0, 1'b0, 1'b0);
      chk("t2_mon_hsync_2w", 8'(MON_HSYNC), 8'd0);
    end

    // 52 lines without VSYNC raise INT and wrap R52; ACK clears INT.
    reset_dut();
    for (int i = 0; i < 51; i++) hpulse(3, 3, 1'b0);
    chk("t3_r52_51", 8'(R52), 8'd51);
    chk("t3_model_r52_51", 8'(m_r52), 8'd51);
    chk("t3_int_before", 8'(INT), 8'd0);
    hpulse(3, 3, 1'b0);
    chk("t3_int_set", 8'(INT), 8'd1);
    chk("t3_r52_wrap", 8'(R52), 8'd0);
    chk("t3_model_int", 8'(m_int), 8'd1);
    INT_ACK = 1'b1;
    cycle();
    INT_ACK = 1'b0;
    chk("t3_int_ack", 8'(INT), 8'd0);

    // VSYNC with R52=40: INT at the 2nd HSYNC end, MON_VSYNC from 2nd to 6th.
    reset_dut();
    for (int i = 0; i < 40; i++) hpulse(3, 3, 1'b0);
    chk("t4_r52_40", 8'(R52), 8'd40);
    hpulse(3, 3, 1'b1);
    chk("t4_mon_vsync_1st", 8'(MON_VSYNC), 8'd0);
    chk("t4_r52_1st", 8'(R52), 8'd41);
    hpulse(3, 3, 1'b1);
    chk("t4_int", 8'(INT), 8'd1);
    chk("t4_r52_2nd", 8'(R52), 8'd0);
    chk("t4_mon_vsync_2nd", 8'(MON_VSYNC), 8'd1);
    hpulse(3, 3, 1'b1);
    hpulse(3, 3, 1'b0);
    hpulse(3, 3, 1'b0);
    chk("t4_mon_vsync_5th", 8'(MON_VSYNC), 8'd1);
    hpulse(3, 3, 1'b0);
    chk("t4_mon_vsync_6th", 8'(MON_VSYNC), 8'd0);
    chk("t4_r52_6th", 8'(R52), 8'd4);

    // Same with R52=20: no interrupt, R52 still cleared.
    reset_dut();
    for (int i = 0; i < 20; i++) hpulse(3, 3, 1'b0);
    hpulse(3, 3, 1'b1);
    hpulse(3, 3, 1'b1);
    chk("t4b_int", 8'(INT), 8'd0);
    chk("t4b_r52", 8'(R52), 8'd0);
    hpulse(3, 3, 1'b0);

    // ACK with INT=1, R52=35 clears bit 5.
    reset_dut();
    for (int i = 0; i < 52 + 35; i++) hpulse(3, 3, 1'b0);
    chk("t5_int_pre", 8'(INT), 8'd1);
    chk("t5_r52_pre", 8'(R52), 8'd35);
    INT_ACK = 1'b1;
    cycle();
    INT_ACK = 1'b0;
    chk("t5_int_ack", 8'(INT), 8'd0);
    chk("t5_r52_ack", 8'(R52), 8'd3);

    // INT_RST coincident with the 52nd HSYNC end wins.
    reset_dut();
    for (int i = 0; i < 51; i++) hpulse(3, 3, 1'b0);
    for (int i = 0; i < 3; i++) char_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    char_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5b_int", 8'(INT), 8'd0);
    chk("t5b_r52", 8'(R52), 8'd0);

    // Mode latches only at an HSYNC rise; async reset mid-pulse.
    reset_dut();
    MODE_REQ = 2'd1;
    hpulse(3, 3, 1'b0);
    chk("t6_mode_1", 8'(MODE), 8'd1);
    MODE_REQ = 2'd2;
    repeat (2) char_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_mode_hold", 8'(MODE), 8'd1);
    char_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_mode_2", 8'(MODE), 8'd2);
    repeat (3) char_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_mon_hsync_pre", 8'(MON_HSYNC), 8'd1);
    #2 RESET = 1'b1;
    #1;
    chk("t6_async_mon_hsync", 8'(MON_HSYNC), 8'd0);
    chk("t6_async_mon_vsync", 8'(MON_VSYNC), 8'd0);
    chk("t6_async_mode", 8'(MODE), 8'd0);
    chk("t6_async_int", 8'(INT), 8'd0);
    chk("t6_async_r52", 8'(R52), 8'd0);
    model_reset();
    @(negedge CLOCK);
    RESET = 1'b0;
    CRTC_HSYNC = 1'b0;
    MODE_REQ = 2'd0;
    cycle();

    // Randomized character-level sync traffic with asynchronous ACK/RMR pulses.
    reset_dut();
    hs_v = 1'b0; vs_v = 1'b0; hs_left = 0; vs_left = 0;
    for (int c = 0; c < 40000; c++) begin
      CLKEN = ($urandom_range(0, 1) == 1);
      if (CLKEN) begin
        if (hs_left == 0) begin
          hs_v = !hs_v;
          hs_left = hs_v ? int'($urandom_range(1, 16)) : int'($urandom_range(2, 24));
        end
        hs_left--;
        if (vs_left == 0) begin
          vs_v = !vs_v;
          vs_left = vs_v ? int'($urandom_range(40, 300)) : int'($urandom_range(400, 2000));
        end
        vs_left--;
      end
      CRTC_HSYNC = hs_v;
      CRTC_VSYNC = vs_v;
      INT_ACK = ($urandom_range(0, 59) == 0);
      INT_RST = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) MODE_REQ = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
